// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller: scan states,
// segment bit positions and the hex-to-segment lookup.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } scan_state_e;

  // Segment bit positions inside the 7-bit segment bus (bit0 = a).
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-low "everything dark" segment pattern.
  localparam logic [6:0] SEG_ALL_OFF = 7'h7F;

  // Places a pattern written left-to-right as a,b,c,d,e,f,g (1 = lit)
  // onto the segment bus bit positions.
  function automatic logic [6:0] seg_lit(input logic [6:0] abcdefg);
    logic [6:0] r;
    r        = '0;
    r[SEG_A] = abcdefg[6];
    r[SEG_B] = abcdefg[5];
    r[SEG_C] = abcdefg[4];
    r[SEG_D] = abcdefg[3];
    r[SEG_E] = abcdefg[2];
    r[SEG_F] = abcdefg[1];
    r[SEG_G] = abcdefg[0];
    return r;
  endfunction

  // Hex digit to lit-segment mask (active-high). b and d are lowercase,
  // A, C, E, F uppercase.
  function automatic logic [6:0] hex_to_lit(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0:    r = seg_lit(7'b1111110);
      4'h1:    r = seg_lit(7'b0110000);
      4'h2:    r = seg_lit(7'b1101101);
      4'h3:    r = seg_lit(7'b1111001);
      4'h4:    r = seg_lit(7'b0110011);
      4'h5:    r = seg_lit(7'b1011011);
      4'h6:    r = seg_lit(7'b1011111);
      4'h7:    r = seg_lit(7'b1110000);
      4'h8:    r = seg_lit(7'b1111111);
      4'h9:    r = seg_lit(7'b1111011);
      4'hA:    r = seg_lit(7'b1110111);
      4'hB:    r = seg_lit(7'b0011111);
      4'hC:    r = seg_lit(7'b1001110);
      4'hD:    r = seg_lit(7'b0111101);
      4'hE:    r = seg_lit(7'b1001111);
      default: r = seg_lit(7'b1000111);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_n_o
);

  // Lookup the lit pattern and invert for active-low drive.
  always_comb begin
    seg_n_o = ~hex_to_lit(hex_i);
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment display scanner with anti-ghost blanking,
// PWM brightness, leading-zero blanking and tear-free frame updates.
//
// Handshake: load_i is a plain one-cycle strobe with no back-pressure; the
// inputs it qualifies are captured into the pending shadow on every cycle
// load_i is high. Pending contents move to the active (displayed) set only
// on the cycle frame_o is high, so a whole frame always shows one snapshot.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_HZ       = 50_000_000,
  parameter int DIGIT_HZ     = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int PWM_BITS     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  input  logic                    lz_blank_i,
  input  logic [PWM_BITS-1:0]     brightness_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int SLOT  = CLK_HZ / DIGIT_HZ;
  localparam int CNT_W = (SLOT > 2) ? $clog2(SLOT) : 1;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

  // Parameter sanity, caught at elaboration.
  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_num_digits
    $error("seg7_scan_ctrl: NUM_DIGITS must be 1..16");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("seg7_scan_ctrl: BLANK_CYCLES must be at least 1");
  end
  if (SLOT <= BLANK_CYCLES + 1) begin : g_bad_slot
    $error("seg7_scan_ctrl: CLK_HZ/DIGIT_HZ must exceed BLANK_CYCLES+1");
  end

  // Scan state.
  scan_state_e            state_q, state_d;
  logic [DIG_W-1:0]       digit_q, digit_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PWM_BITS-1:0]    pwm_q, pwm_d;
  logic                   frame_q, frame_d;

  // Pending shadow and active (displayed) snapshot.
  logic [4*NUM_DIGITS-1:0] pend_value_q, act_value_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q, act_dp_q;
  logic [NUM_DIGITS-1:0]   pend_den_q, act_den_q;
  logic                    pend_lz_q, act_lz_q;

  // Registered outputs.
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  // Per-digit visibility after enable and leading-zero blanking.
  logic [NUM_DIGITS-1:0] nz_at_or_above;
  logic [NUM_DIGITS-1:0] lz_keep;
  logic [NUM_DIGITS-1:0] visible;
  logic                  seen_nz;

  logic [3:0] cur_nibble;
  logic [6:0] cur_seg_n;

  // State register for the scan FSM and its counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      digit_q <= '0;
      cnt_q   <= '0;
      pwm_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_d;
      frame_q <= frame_d;
    end
  end

  // Next-state logic: slot counter spans blank + on; frame pulses on every
  // entry into the blank of digit 0.
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    cnt_d   = cnt_q;
    pwm_d   = pwm_q;
    frame_d = 1'b0;
    if (!en_i) begin
      state_d = ST_IDLE;
      digit_d = '0;
      cnt_d   = '0;
      pwm_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          digit_d = '0;
          cnt_d   = '0;
          pwm_d   = '0;
          frame_d = 1'b1;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          pwm_d = '0;
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_ON;
          end
        end
        ST_ON: begin
          pwm_d = pwm_q + PWM_BITS'(1);
          if (cnt_q == SLOT_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            pwm_d   = '0;
            if (digit_q == DIG_LAST) begin
              digit_d = '0;
              frame_d = 1'b1;
            end else begin
              digit_d = digit_q + DIG_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          digit_d = '0;
          cnt_d   = '0;
          pwm_d   = '0;
        end
      endcase
    end
  end

  // Pending capture on load_i; active update only on the frame_o cycle, so a
  // load in that same cycle lands in pending for the following frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_value_q <= '0;
      pend_dp_q    <= '0;
      pend_den_q   <= '0;
      pend_lz_q    <= 1'b0;
      act_value_q  <= '0;
      act_dp_q     <= '0;
      act_den_q    <= '0;
      act_lz_q     <= 1'b0;
    end else begin
      if (load_i) begin
        pend_value_q <= value_i;
        pend_dp_q    <= dp_i;
        pend_den_q   <= digit_en_i;
        pend_lz_q    <= lz_blank_i;
      end
      if (frame_q) begin
        act_value_q <= pend_value_q;
        act_dp_q    <= pend_dp_q;
        act_den_q   <= pend_den_q;
        act_lz_q    <= pend_lz_q;
      end
    end
  end

  // Leading-zero visibility: a digit survives if it or any higher digit is
  // non-zero; digit 0 always survives so an all-zero value shows "0".
  always_comb begin
    nz_at_or_above = '0;
    seen_nz        = 1'b0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      seen_nz           = seen_nz | (act_value_q[4*d +: 4] != 4'h0);
      nz_at_or_above[d] = seen_nz;
    end
    lz_keep    = nz_at_or_above;
    lz_keep[0] = 1'b1;
    visible    = act_den_q & (act_lz_q ? lz_keep : {NUM_DIGITS{1'b1}});
  end

  // Nibble of the digit currently being scanned.
  always_comb begin
    cur_nibble = act_value_q[{digit_q, 2'b00} +: 4];
  end

  seg7_hex_decode u_hex_decode (
    .hex_i   (cur_nibble),
    .seg_n_o (cur_seg_n)
  );

  // Output next values: dark unless scanning a visible digit in ON; the
  // anode is further gated by the PWM phase against live brightness.
  always_comb begin
    seg_d = SEG_ALL_OFF;
    dp_d  = 1'b1;
    an_d  = {NUM_DIGITS{1'b1}};
    if (en_i && (state_q == ST_ON) && visible[digit_q]) begin
      seg_d = cur_seg_n;
      dp_d  = ~act_dp_q[digit_q];
      if (pwm_q <= brightness_i) begin
        an_d[digit_q] = 1'b0;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= SEG_ALL_OFF;
      dp_q  <= 1'b1;
      an_q  <= {NUM_DIGITS{1'b1}};
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: 4 digits, 10-cycle slots (2 blank + 8 on),
// 2-bit PWM, 40-cycle frames.
module tb_seg7_scan_ctrl;

  // Clock / reset / DUT signals.
  logic        clk = 1'b0;
  logic        rst;
  logic        en_i;
  logic        load_i;
  logic [15:0] value_i;
  logic [3:0]  dp_i;
  logic [3:0]  digit_en_i;
  logic        lz_blank_i;
  logic [1:0]  brightness_i;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        frame_o;

  int checks   = 0;
  int failures = 0;

  // Hand-computed active-low patterns {digit3, digit2, digit1, digit0}.
  // 1=79, 2=24, A=08, F=0E (segments a,e,f,g lit).
  localparam logic [27:0] PAT_12AF = {7'h79, 7'h24, 7'h08, 7'h0E};
  // 0C0E with leading-zero blanking: C=46, 0=40, E=06; digit3 dark.
  localparam logic [27:0] PAT_0C0E = {7'h7F, 7'h46, 7'h40, 7'h06};
  localparam logic [27:0] PAT_0007 = {7'h7F, 7'h7F, 7'h7F, 7'h78};
  localparam logic [27:0] PAT_0000 = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [27:0] PAT_DARK = {7'h7F, 7'h7F, 7'h7F, 7'h7F};

  seg7_scan_ctrl #(
    .NUM_DIGITS   (4),
    .CLK_HZ       (1000),
    .DIGIT_HZ     (100),
    .BLANK_CYCLES (2),
    .PWM_BITS     (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en_i),
    .load_i       (load_i),
    .value_i      (value_i),
    .dp_i         (dp_i),
    .digit_en_i   (digit_en_i),
    .lz_blank_i   (lz_blank_i),
    .brightness_i (brightness_i),
    .seg_o        (seg_o),
    .dp_o         (dp_o),
    .an_o         (an_o),
    .frame_o      (frame_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Comparison: counts and reports.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_inputs(input logic [15:0] v, input logic [3:0] den,
                            input logic [3:0] dp, input logic lz);
    value_i    = v;
    digit_en_i = den;
    dp_i       = dp;
    lz_blank_i = lz;
  endtask

  // Waits (bounded) for frame_o; the expiry counts as a failed comparison.
  task automatic wait_frame(input string tag, input int max_cyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      load_i = 1'b0;
      if (frame_o) seen = 1'b1;
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  // Checks the 40 cycles after a frame_o sample. Digit d is dark at offsets
  // 10d+1..10d+2 and in ON at 10d+3..10d+10, where the PWM phase is
  // (offset-(10d+3)) mod 4. Optionally pulses load_i at cycle load_k.
  task automatic check_frame(input string tag, input logic [27:0] pats,
                             input logic [3:0] vis, input logic [3:0] dpm,
                             input int bright, input int load_k,
                             input logic [15:0] nv, input logic [3:0] nden,
                             input logic [3:0] ndp, input logic nlz);
    int d, off, j;
    logic on;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      load_i  = 1'b0;
      d       = (k - 1) / 10;
      off     = (k - 1) % 10;
      on      = (off >= 2);
      j       = off - 2;
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
      if (on && vis[d]) begin
        exp_seg = pats[7*d +: 7];
        exp_dp  = ~dpm[d];
        if ((j % 4) <= bright) exp_an[d] = 1'b0;
      end
      check_eq($sformatf("%s_k%0d_an", tag, k), 32'(an_o), 32'(exp_an));
      check_eq($sformatf("%s_k%0d_seg", tag, k), 32'(seg_o), 32'(exp_seg));
      check_eq($sformatf("%s_k%0d_dp", tag, k), 32'(dp_o), 32'(exp_dp));
      check_eq($sformatf("%s_k%0d_frame", tag, k), 32'(frame_o), 32'(k == 40));
      if (k == load_k) begin
        set_inputs(nv, nden, ndp, nlz);
        load_i = 1'b1;
      end
    end
  endtask

  task automatic check_dark(input string tag);
    check_eq({tag, "_an"}, 32'(an_o), 32'hF);
    check_eq({tag, "_seg"}, 32'(seg_o), 32'h7F);
    check_eq({tag, "_dp"}, 32'(dp_o), 32'h1);
    check_eq({tag, "_frame"}, 32'(frame_o), 32'h0);
  endtask

  initial begin
    rst          = 1'b1;
    en_i         = 1'b0;
    load_i       = 1'b0;
    brightness_i = 2'd3;
    set_inputs(16'h0000, 4'h0, 4'h0, 1'b0);

    // Reset state.
    @(negedge clk);
    check_dark("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_dark("idle_en0");

    // Load 12AF with dp on digit 1, then enable scanning.
    set_inputs(16'h12AF, 4'hF, 4'b0010, 1'b0);
    load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    en_i   = 1'b1;
    wait_frame("start_frame", 1);

    // Frame 1: basic scan. Frame 2: load 0C0E/lz mid-frame, display unchanged.
    check_frame("f1", PAT_12AF, 4'hF, 4'b0010, 3, -1, 16'h0, 4'h0, 4'h0, 1'b0);
    check_frame("f2", PAT_12AF, 4'hF, 4'b0010, 3, 15, 16'h0C0E, 4'hF, 4'h0, 1'b1);

    // Load on the frame_o cycle itself: lands in pending, shows a frame later.
    set_inputs(16'h0007, 4'hF, 4'h0, 1'b1);
    load_i = 1'b1;
    check_frame("f3", PAT_0C0E, 4'b0111, 4'h0, 3, -1, 16'h0, 4'h0, 4'h0, 1'b0);
    check_frame("f4", PAT_0007, 4'b0001, 4'h0, 3, 5, 16'h0000, 4'hF, 4'h0, 1'b1);
    check_frame("f5", PAT_0000, 4'b0001, 4'h0, 3, 5, 16'h12AF, 4'b1011, 4'b0010, 1'b0);

    // Brightness 0 then 2, digit 2 disabled.
    brightness_i = 2'd0;
    check_frame("f6", PAT_12AF, 4'b1011, 4'b0010, 0, -1, 16'h0, 4'h0, 4'h0, 1'b0);
    brightness_i = 2'd2;
    check_frame("f7", PAT_12AF, 4'b1011, 4'b0010, 2, -1, 16'h0, 4'h0, 4'h0, 1'b0);

    // en_i drop mid-slot (digit 1 ON, PWM phase 1).
    repeat (14) @(negedge clk);
    check_eq("endrop_pre_an", 32'(an_o), 32'hD);
    en_i = 1'b0;
    @(negedge clk);
    check_dark("endrop_next");
    repeat (3) begin
      @(negedge clk);
      check_dark("endrop_hold");
    end
    en_i = 1'b1;
    wait_frame("restart_frame", 1);
    check_frame("f8", PAT_12AF, 4'b1011, 4'b0010, 2, -1, 16'h0, 4'h0, 4'h0, 1'b0);

    // Reset mid-ON (digit 1, PWM phase 2).
    repeat (15) @(negedge clk);
    check_eq("prerst_an", 32'(an_o), 32'hD);
    check_eq("prerst_seg", 32'(seg_o), 32'h08);
    rst = 1'b1;
    #1;
    check_dark("rst_async");
    @(negedge clk);
    check_dark("rst_held");
    rst = 1'b0;
    wait_frame("rst_release_frame", 1);
    // Active registers cleared: nothing lit. Reload 12AF mid-frame.
    check_frame("f9", PAT_DARK, 4'h0, 4'h0, 2, 5, 16'h12AF, 4'hF, 4'b0010, 1'b0);
    brightness_i = 2'd1;
    check_frame("f10", PAT_12AF, 4'hF, 4'b0010, 1, -1, 16'h0, 4'h0, 4'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
